// File: rtl/sd_crc_16_pkg.sv
// Shared constants for the SD data-line CRC-16 (CCITT, x^16+x^12+x^5+1).
// Used by the data-path controller and by each per-lane sd_crc_16 instance.
package sd_crc_16_pkg;

  localparam int unsigned CrcWidth = 16;
  // Tap pattern: x^12, x^5 and x^0 terms; the x^16 term is the implicit shift-out.
  localparam logic [CrcWidth-1:0] CrcPoly = 16'h1021;
  localparam logic [CrcWidth-1:0] CrcInit = 16'h0000;

endpackage

// File: rtl/sd_crc_16.sv
// sd_crc_16: bit-serial CRC-16-CCITT generator/checker for one SD data lane.
// Initial value 0x0000, MSB-first, no reflection, no final XOR.
//
// Ports
//   BITVAL   in   1  serial data bit folded in on an enabled cycle
//   Enable   in   1  advance the CRC one bit this cycle; hold when low
//   CLK      in   1  clock, rising edge
//   RST      in   1  synchronous active-high reset, priority over Enable
//   CRC      out 16  registered CRC; CRC[15] is transmitted first
//   crc_zero out  1  only with SD_CRC16_ZERO_FLAG_EN defined: high when CRC == 0
//
// Configuration macro: SD_CRC16_ZERO_FLAG_EN (adds crc_zero for residue checks,
// where data followed by its own CRC leaves the register at zero).
module sd_crc_16
  import sd_crc_16_pkg::*;
(
  input  logic                BITVAL,
  input  logic                Enable,
  input  logic                CLK,
  input  logic                RST,
`ifdef SD_CRC16_ZERO_FLAG_EN
  output logic [CrcWidth-1:0] CRC,
  output logic                crc_zero
`else
  output logic [CrcWidth-1:0] CRC
`endif
);

  logic [CrcWidth-1:0] crc_q;
  logic [CrcWidth-1:0] crc_d;
  logic                inv;

  assign inv = BITVAL ^ crc_q[CrcWidth-1];

  // Shift left one place; feedback lands on bit 0 and is XORed into bits 5 and 12.
  always_comb begin
    crc_d = crc_q;
    if (Enable) begin
      crc_d = {crc_q[CrcWidth-2:0], 1'b0} ^ (inv ? CrcPoly : CrcInit);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      crc_q <= CrcInit;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign CRC = crc_q;

`ifdef SD_CRC16_ZERO_FLAG_EN
  assign crc_zero = (crc_q == CrcInit);
`endif

endmodule

// File: tb/tb_sd_crc_16.sv
// Self-checking bench for sd_crc_16. The reference model computes the CRC as
// the remainder of (message * x^16) divided by 0x11021 using long division over
// the queue of accepted bits.
module tb_sd_crc_16;

  logic        bitval;
  logic        enable;
  logic        clk;
  logic        rst;
  logic [15:0] crc;
`ifdef SD_CRC16_ZERO_FLAG_EN
  logic        crc_zero;
`endif

  int checks = 0;
  int errors = 0;

  bit msg[$];

  sd_crc_16 dut (
    .BITVAL  (bitval),
    .Enable  (enable),
    .CLK     (clk),
    .RST     (rst),
`ifdef SD_CRC16_ZERO_FLAG_EN
    .CRC     (crc),
    .crc_zero(crc_zero)
`else
    .CRC     (crc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remainder of msg * x^16 modulo the generator polynomial.
  function automatic logic [15:0] model_crc();
    bit [16:0] r = '0;
    int n = msg.size();
    for (int i = 0; i < n + 16; i++) begin
      bit b = (i < n) ? msg[i] : 1'b0;
      r = {r[15:0], b};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  // One clock: inputs applied at negedge, outputs sampled 1 after posedge.
  task automatic step(input logic r, input logic en, input logic b);
    @(negedge clk);
    rst    = r;
    enable = en;
    bitval = b;
    @(posedge clk);
    #1;
    if (r) msg.delete();
    else if (en) msg.push_back(b);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (crc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_2cyc: got %h expected 0000", crc);
    end
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (crc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_over_enable: got %h expected 0000", crc);
    end
  endtask

  task automatic test_single_bits();
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (crc !== 16'h1021) begin
      errors++;
      $display("FAIL first_bit_one: got %h expected 1021", crc);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (crc !== 16'h2042) begin
      errors++;
      $display("FAIL second_bit_zero: got %h expected 2042", crc);
    end
  endtask

  task automatic test_hold();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, logic'(i[0]));
      checks++;
      if (crc !== 16'h1021) begin
        errors++;
        $display("FAIL hold_cycle%0d: got %h expected 1021", i, crc);
      end
    end
  endtask

  task automatic test_all_ones();
    logic [15:0] exp;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4096; i++) step(1'b0, 1'b1, 1'b1);
    exp = model_crc();
    checks++;
    if (crc !== exp) begin
      errors++;
      $display("FAIL ones_4096_model: got %h expected %h", crc, exp);
    end
    checks++;
    if (crc !== 16'h7FA1) begin
      errors++;
      $display("FAIL ones_4096_const: got %h expected 7fa1", crc);
    end
`ifdef SD_CRC16_ZERO_FLAG_EN
    checks++;
    if (crc_zero !== 1'b0) begin
      errors++;
      $display("FAIL zero_flag_nonzero: got %b expected 0", crc_zero);
    end
    for (int i = 15; i >= 0; i--) step(1'b0, 1'b1, exp[i]);
    checks++;
    if (crc !== 16'h0000) begin
      errors++;
      $display("FAIL residue_crc: got %h expected 0000", crc);
    end
    checks++;
    if (crc_zero !== 1'b1) begin
      errors++;
      $display("FAIL residue_flag: got %b expected 1", crc_zero);
    end
`endif
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, logic'($urandom_range(0, 1)));
    step(1'b1, 1'b0, logic'($urandom_range(0, 1)));
    checks++;
    if (crc !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_clear: got %h expected 0000", crc);
    end
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (crc !== 16'h1021) begin
      errors++;
      $display("FAIL mid_reset_restart: got %h expected 1021", crc);
    end
  endtask

  // Random enable/data with occasional reset, model checked every cycle.
  task automatic test_random();
    logic [15:0] exp;
    int bad = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 49) == 0), logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 1)));
      exp = model_crc();
      checks++;
      if (crc !== exp) begin
        errors++;
        if (bad < 10) $display("FAIL random_cyc%0d: got %h expected %h", i, crc, exp);
        bad++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    step(1'b1, 1'b0, 1'b0);
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 64; i++) step(1'b0, 1'b1, logic'($urandom_range(0, 1)));
      exp = model_crc();
      checks++;
      if (crc !== exp) begin
        errors++;
        $display("FAIL b2b_block%0d: got %h expected %h", blk, crc, exp);
      end
      step(1'b1, 1'b1, 1'b1);
      checks++;
      if (crc !== 16'h0000) begin
        errors++;
        $display("FAIL b2b_reset%0d: got %h expected 0000", blk, crc);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    bitval = 1'b0;
    test_reset();
    test_single_bits();
    test_hold();
    test_all_ones();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_crc_16.md
SD_CRC_16 -- requirements
Module: sd_crc_16

Interface
REQ-001 Parameters: none; polynomial and width are fixed constants.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 BITVAL  input  1  serial data bit to fold into the CRC on an enabled cycle.
REQ-005 Enable  input  1  when high, the CRC advances one bit this cycle; when low, the CRC holds.
REQ-006 CRC  output  16  current CRC register value, registered; CRC[15] is the bit transmitted first.
REQ-007 Port order for positional instantiation SHALL be BITVAL, Enable, CLK, RST, CRC.

Function
REQ-008 Polynomial SHALL be CRC-16-CCITT, x^16+x^12+x^5+1, with initial value 0x0000, no reflection and no final XOR.
REQ-009 Feedback term inv = BITVAL XOR CRC[15], combinational.
REQ-010 On a rising CLK edge with RST low and Enable high, the register SHALL update as follows:
- CRC[0] <= inv
- CRC[5] <= CRC[4] XOR inv
- CRC[12] <= CRC[11] XOR inv
- every other bit n <= CRC[n-1]
REQ-011 On a rising CLK edge with RST low and Enable low, CRC SHALL hold its value.
REQ-012 Latency: one cycle; CRC reflects every bit accepted up to and including the previous edge.
REQ-013 The block SHALL contain no internal counters; the user sequences bits and reads CRC[15] down to CRC[0] (MSB first) after the last enabled bit.
REQ-014 An X-free CRC SHALL be guaranteed whenever the block has been reset and BITVAL is known on every enabled cycle.

Reset
REQ-015 When RST is high at a rising CLK edge, CRC SHALL become 0x0000 regardless of Enable and BITVAL.
REQ-016 Reset SHALL have priority over Enable.
REQ-017 Reset asserted mid-stream SHALL discard the partial CRC; the next enabled bit after RST deasserts starts from 0x0000.
REQ-018 Holding RST high for multiple cycles SHALL keep CRC at 0x0000 (the controller holds reset while idle).

Configuration
REQ-019 Macro SD_CRC16_ZERO_FLAG_EN, when defined, SHALL add output port crc_zero (1 bit, appended after CRC).
- crc_zero is combinationally high when CRC == 0x0000.
- This supports receive-side residue checking: data followed by its CRC yields zero.
REQ-020 Without SD_CRC16_ZERO_FLAG_EN, the port and its logic SHALL be absent and the interface SHALL be exactly REQ-002..REQ-006.

Structure
REQ-021 A shared package/defines file SHALL hold the following constants, for reuse by the data-path controller and its per-lane CRC instances:
- CRC width (16)
- polynomial tap constant 16'h1021
- reset value 16'h0000
REQ-022 No sub-modules; the block is a single flat register with XOR taps, one instance per data lane in the parent.

Verification
REQ-023 Assert RST for 2 cycles -> CRC == 0x0000; with Enable high and RST high, BITVAL=1 -> CRC stays 0x0000.
REQ-024 After reset, one enabled bit BITVAL=1 -> CRC == 0x1021; one more enabled bit BITVAL=0 -> CRC == 0x2042.
REQ-025 After reset, enabled bit BITVAL=1, then Enable low for 5 cycles with BITVAL toggling -> CRC remains 0x1021.
REQ-026 After reset, 4096 enabled bits of 1 (512 bytes of 0xFF) -> CRC == 0x7FA1.
REQ-027 Feed 100 random bits, assert RST for one cycle, then feed BITVAL=1 once -> CRC == 0x1021.
REQ-028 With SD_CRC16_ZERO_FLAG_EN defined: after the REQ-026 stream, feed its 16 CRC bits MSB first -> CRC == 0x0000 and crc_zero == 1.
